seq_divider8x4: RTL



---
 rtl/divider_pkg.sv | 23 ++
 rtl/div_step.sv | 23 ++
 rtl/seq_divider8x4.sv | 94 +++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider family.
// Also used by the div_step datapath slice and any future unrolled divider.
package divider_pkg;

    localparam int DEF_DIVIDEND_W = 8;
    localparam int DEF_DIVISOR_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Iteration counter must hold the value DIVIDEND_W itself, hence the +1.
    function automatic int counter_width(input int dividend_w);
        return $clog2(dividend_w + 1);
    endfunction

    localparam int CNT_W = counter_width(DEF_DIVIDEND_W);

    localparam logic [DEF_DIVIDEND_W-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational so it can be chained into an unrolled divider later.
module div_step
    import divider_pkg::*;
#(
    parameter int W = DEF_DIVISOR_W
) (
    input  logic [W-1:0] p,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] p_next,
    output logic         q_bit
);

    logic [W:0] t;

    assign t     = {p, bit_in};
    assign q_bit = (t >= {1'b0, divisor});

    // p < divisor on entry, so t - divisor < divisor and fits back into W bits.
    assign p_next = q_bit ? W'(t - {1'b0, divisor}) : t[W-1:0];

endmodule

// File: rtl/seq_divider8x4.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Results hold between operations and update only on the edge that enters DONE.
module seq_divider8x4
    import divider_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CW = counter_width(DIVIDEND_W);

    div_state_t            state;
    logic [DIVIDEND_W-1:0] s;
    // The extra top bit of P only ever exists inside the trial value in div_step.
    logic [DIVISOR_W-1:0]  p;
    logic [DIVISOR_W-1:0]  divisor_r;
    logic [CW-1:0]         cnt;

    logic [DIVISOR_W-1:0]  p_next;
    logic                  q_bit;
    logic [DIVIDEND_W-1:0] s_next;
    logic                  accept;

    div_step #(.W(DIVISOR_W)) u_step (
        .p       (p),
        .bit_in  (s[DIVIDEND_W-1]),
        .divisor (divisor_r),
        .p_next  (p_next),
        .q_bit   (q_bit)
    );

    assign s_next = {s[DIVIDEND_W-2:0], q_bit};
    assign accept = start && (state != RUN);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            s           <= '0;
            p           <= '0;
            divisor_r   <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept && divisor != '0) begin
                        s         <= dividend;
                        p         <= '0;
                        divisor_r <= divisor;
                        cnt       <= CW'(DIVIDEND_W);
                        state     <= RUN;
                    end else if (accept) begin
                        quotient    <= DIVIDEND_W'(DIV_ZERO_QUOT);
                        remainder   <= '0;
                        div_by_zero <= 1'b1;
                        state       <= DONE;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    s   <= s_next;
                    p   <= p_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        quotient    <= s_next;
                        remainder   <= p_next;
                        div_by_zero <= 1'b0;
                        state       <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
